dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 16 +
 rtl/define.sv | 4 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Default request-accept to rsp_valid distance; 4-bit counter covers 1..15.
    localparam int LATENCY_DEFAULT = 2;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/define.sv
`ifndef DEFINE_SV
`define DEFINE_SV
`define DATA_WIDTH 32
`endif

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Latency: write and read both take effect on the edge where we/re is high.
// Backpressure: none; the caller strobes we/re for exactly one cycle per access.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-masked write and registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of a byte-enabled word array.
// Latency: rsp_valid rises LATENCY edges after the accept edge (accept edge counts as 1).
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
`include "define.sv"

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = LATENCY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [`DATA_WIDTH-1:0] req_addr,
    input  logic [`DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]             req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [`DATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_error,
    output logic                   busy
);

    localparam int DW = `DATA_WIDTH;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [DW-3:0]    DEPTH_LIM = (DW-2)'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             lat_write;
    logic [DW-1:0]    lat_addr;
    logic [DW-1:0]    lat_wdata;
    logic [3:0]       lat_be;

    // Set when the response carries array read data; gates rsp_rdata.
    logic             rsp_load;
    logic [DW-1:0]    arr_rdata;

    logic             accept;
    logic             commit;
    logic             acc_write;
    logic [DW-1:0]    acc_addr;
    logic [DW-1:0]    acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_err;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready;

    // With LATENCY=1 the access happens on the accept edge, so it must use the live
    // request fields; otherwise the latched copy is used.
    assign acc_write = (state == IDLE) ? req_write : lat_write;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_be    = (state == IDLE) ? req_be    : lat_be;

    assign acc_err = (acc_addr[1:0] != 2'b00) | (acc_addr[DW-1:2] >= DEPTH_LIM);

    // The edge on which the FSM enters RESP is the edge that performs the access.
    assign commit = ((state == WAIT) && (cnt == CNT_W'(1))) ||
                    ((state == IDLE) && accept && (LATENCY == 1));

    // Registered AND of response flag and array output: zero for stores, errors and idle.
    assign rsp_rdata = rsp_load ? arr_rdata : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (commit & acc_write & ~acc_err),
        .re    (commit & ~acc_write & ~acc_err),
        .be    (acc_be),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata[31:0]),
        .rdata (arr_rdata)
    );

    // Request/response FSM with latency counter and registered response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (commit) begin
                            state     <= RESP;
                            cnt       <= '0;
                            rsp_valid <= 1'b1;
                            rsp_error <= acc_err;
                            rsp_load  <= ~acc_write & ~acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (commit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= acc_err;
                        rsp_load  <= ~acc_write & ~acc_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        rsp_load  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance with host-driven rsp_ready, LATENCY=1 instance with rsp_ready tied high.
// Latency: expects rsp_valid on the LATENCY-th edge counting the accept edge.
// Backpressure: scoreboard queues hold expected responses until the DUT presents them.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid_a = 1'b0, req_write_a = 1'b0, rsp_ready_a = 1'b0;
    logic [31:0] req_addr_a = '0, req_wdata_a = '0;
    logic [3:0]  req_be_a = '0;
    logic        req_ready_a, rsp_valid_a, rsp_error_a, busy_a;
    logic [31:0] rsp_rdata_a;

    logic        req_valid_b = 1'b0, req_write_b = 1'b0;
    logic [31:0] req_addr_b = '0, req_wdata_b = '0;
    logic [3:0]  req_be_b = '0;
    logic        req_ready_b, rsp_valid_b, rsp_error_b, busy_b;
    logic [31:0] rsp_rdata_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_a),
        .req_ready (req_ready_a),
        .req_write (req_write_a),
        .req_addr  (req_addr_a),
        .req_wdata (req_wdata_a),
        .req_be    (req_be_a),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready_a),
        .rsp_rdata (rsp_rdata_a),
        .rsp_error (rsp_error_a),
        .busy      (busy_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_write (req_write_b),
        .req_addr  (req_addr_b),
        .req_wdata (req_wdata_b),
        .req_be    (req_be_b),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (1'b1),
        .rsp_rdata (rsp_rdata_b),
        .rsp_error (rsp_error_b),
        .busy      (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One LATENCY=2 transaction; hold>0 keeps rsp_ready low for that many cycles in RESP
    // and offers a competing store that must be ignored.
    task automatic txn_a(input string tag, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        int   n;
        q_a.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_valid_a = 1'b1;
        req_write_a = w;
        req_addr_a  = addr;
        req_wdata_a = wdata;
        req_be_a    = be;
        check({tag, " req_ready"}, 32'(req_ready_a), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            req_valid_a = 1'b0;
            n++;
        end while (!rsp_valid_a && n < 20);
        check({tag, " latency"}, 32'(n), 32'd2);
        e = q_a.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid_a = 1'b1;
                req_write_a = 1'b1;
                req_addr_a  = 32'h10;
                req_wdata_a = 32'h12345678;
                req_be_a    = 4'hF;
            end
            check({tag, " hold rsp_valid"}, 32'(rsp_valid_a), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata_a, e.rdata);
            check({tag, " hold req_ready"}, 32'(req_ready_a), 32'd0);
        end
        req_valid_a = 1'b0;
        check({tag, " rdata"}, rsp_rdata_a, e.rdata);
        check({tag, " error"}, 32'(rsp_error_a), 32'(e.err));
        @(negedge clk);
        rsp_ready_a = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_a = 1'b0;
        check({tag, " post rsp_valid"}, 32'(rsp_valid_a), 32'd0);
        check({tag, " post rdata"}, rsp_rdata_a, 32'd0);
        check({tag, " post error"}, 32'(rsp_error_a), 32'd0);
        check({tag, " post req_ready"}, 32'(req_ready_a), 32'd1);
    endtask

    // One LATENCY=1 transaction with rsp_ready tied high: single-cycle response pulse.
    task automatic txn_b(input string tag, input logic w, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        q_b.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_valid_b = 1'b1;
        req_write_b = w;
        req_addr_b  = addr;
        req_wdata_b = wdata;
        req_be_b    = be;
        check({tag, " req_ready"}, 32'(req_ready_b), 32'd1);
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        e = q_b.pop_front();
        check({tag, " rsp_valid"}, 32'(rsp_valid_b), 32'd1);
        check({tag, " rdata"}, rsp_rdata_b, e.rdata);
        check({tag, " error"}, 32'(rsp_error_b), 32'(e.err));
        check({tag, " req_ready in RESP"}, 32'(req_ready_b), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " pulse end"}, 32'(rsp_valid_b), 32'd0);
        check({tag, " req_ready back"}, 32'(req_ready_b), 32'd1);
        check({tag, " rdata cleared"}, rsp_rdata_b, 32'd0);
    endtask

    initial begin
        // Reset values on both instances.
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready_a", 32'(req_ready_a), 32'd1);
        check("rst rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        check("rst rdata_a", rsp_rdata_a, 32'd0);
        check("rst error_a", 32'(rsp_error_a), 32'd0);
        check("rst busy_a", 32'(busy_a), 32'd0);
        check("rst req_ready_b", 32'(req_ready_b), 32'd1);
        check("rst rsp_valid_b", 32'(rsp_valid_b), 32'd0);
        check("rst busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full-word store then load back.
        txn_a("st 0x10",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0);
        txn_a("ld 0x10",   1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0);

        // Byte-lane store merges into existing word.
        txn_a("st be1",    1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0,        1'b0, 0);
        txn_a("ld merged", 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);

        // Misaligned and out-of-range accesses.
        txn_a("ld 0x13",   1'b0, 32'h13,  32'h0,         4'h0, 32'h0,        1'b1, 0);
        txn_a("ld 0x400",  1'b0, 32'h400, 32'h0,         4'h0, 32'h0,        1'b1, 0);
        txn_a("st 0x0",    1'b1, 32'h0,   32'h0BADF00D,  4'hF, 32'h0,        1'b0, 0);
        txn_a("st 0x400",  1'b1, 32'h400, 32'hFFFFFFFF,  4'hF, 32'h0,        1'b1, 0);
        txn_a("ld 0x0",    1'b0, 32'h0,   32'h0,         4'h0, 32'h0BADF00D, 1'b0, 0);

        // Store with no byte enables is a clean no-op.
        txn_a("st be0",    1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 0);
        txn_a("ld be0",    1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);

        // Backpressure in RESP for 5 cycles with an ignored competing store.
        txn_a("ld hold",   1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 5);
        txn_a("ld after",  1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);

        // Reset during WAIT of a store aborts it without touching storage.
        txn_a("st 0x20",   1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0);
        @(negedge clk);
        req_valid_a = 1'b1;
        req_write_a = 1'b1;
        req_addr_a  = 32'h20;
        req_wdata_a = 32'h11111111;
        req_be_a    = 4'hF;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        check("abort busy before rst", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort req_ready", 32'(req_ready_a), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("abort rdata", rsp_rdata_a, 32'd0);
        check("abort error", 32'(rsp_error_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort still idle", 32'(rsp_valid_a), 32'd0);
        txn_a("ld 0x20",   1'b0, 32'h20, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0);

        // LATENCY=1 instance: one-edge responses, single-cycle pulses.
        txn_b("b st 0x8",  1'b1, 32'h8,   32'h00000055, 4'hF, 32'h0,        1'b0);
        txn_b("b ld 0x8",  1'b0, 32'h8,   32'h0,        4'h0, 32'h00000055, 1'b0);
        txn_b("b ld 0x401",1'b0, 32'h401, 32'h0,        4'h0, 32'h0,        1'b1);

        check("scoreboard a drained", 32'(q_a.size()), 32'd0);
        check("scoreboard b drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
